// File: rtl/fft_spectrum_bander_if.sv
// Bundles the FFT-output stream (sink side) and the VGA register-write bus.
// The bander is the slave; whatever feeds the stream and watches the writes is the master.
interface fft_spectrum_bander_if #(
  parameter int DATA_W = 16,
  parameter int BANDS  = 4
);
  localparam int AW = (BANDS > 1) ? $clog2(BANDS) : 1;

  logic                     sink_valid;
  logic                     sink_ready;
  logic                     sink_sop;
  logic                     sink_eop;
  logic signed [DATA_W-1:0] sink_real;
  logic signed [DATA_W-1:0] sink_imag;
  logic [15:0]              vga_dat;
  logic [AW-1:0]            vga_addr;
  logic                     vga_dowrite;
  logic                     vga_select;
  logic                     frame_err;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    input  sink_ready, vga_dat, vga_addr, vga_dowrite, vga_select, frame_err
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    output sink_ready, vga_dat, vga_addr, vga_dowrite, vga_select, frame_err
  );
endinterface

// File: rtl/fft_spectrum_bander.sv
// Reduces one FFT frame (SAMPLES bins, sop/eop framed) to BANDS |re|+|im| band sums
// and writes them, saturated to 16 bits, to consecutive VGA registers.
module fft_spectrum_bander #(
  parameter int SAMPLES   = 4096,
  parameter int BANDS     = 4,
  parameter int OUT_SHIFT = 10,
  parameter int DATA_W    = 16
) (
  input logic fft_clk,
  input logic reset,
  fft_spectrum_bander_if.slave bus
);
  localparam int CW      = $clog2(SAMPLES);
  localparam int AW      = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int BAND_SH = $clog2(SAMPLES / (2 * BANDS));
  localparam int MAG_W   = DATA_W + 1;
  localparam int ACC_W   = MAG_W + BAND_SH;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [DATA_W-1:0] x);
    logic signed [MAG_W-1:0] ext;
    ext = MAG_W'(x);
    return (ext < 0) ? unsigned'(MAG_W'(-ext)) : unsigned'(ext);
  endfunction

  function automatic logic [15:0] sat16(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] s;
    s = a >> OUT_SHIFT;
    return (s > ACC_W'(16'hFFFF)) ? 16'hFFFF : 16'(s);
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    fidx;
  logic [ACC_W-1:0] acc [BANDS];

  logic             accept, restart, acc_en, cnt_inc, err_nxt, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CW-1:0]    bin;
  logic [MAG_W-1:0] mag;
  logic [AW-1:0]    band;
  logic             in_half;

  logic [15:0]      dat;
  logic [AW-1:0]    addr;
  logic             dowrite;
  logic             err;

  assign bus.sink_ready  = (state != FLUSH) && !reset;
  assign bus.vga_dat     = dat;
  assign bus.vga_addr    = addr;
  assign bus.vga_dowrite = dowrite;
  assign bus.vga_select  = dowrite;
  assign bus.frame_err   = err;

  assign accept  = bus.sink_valid && bus.sink_ready;
  assign mag     = abs_mag(bus.sink_real) + abs_mag(bus.sink_imag);
  // A restarting beat is always bin 0, whatever cnt currently holds.
  assign bin     = restart ? '0 : cnt;
  assign in_half = bin < CW'(SAMPLES / 2);
  assign band    = AW'(bin >> BAND_SH);

  always_ff @(posedge fft_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    acc_en    = 1'b0;
    cnt_inc   = 1'b0;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = fidx;
    unique case (state)
      IDLE: begin
        if (accept && bus.sink_sop) begin
          if (bus.sink_eop) begin
            err_nxt = 1'b1;
          end else begin
            restart   = 1'b1;
            acc_en    = 1'b1;
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (bus.sink_sop) begin
            err_nxt = 1'b1;
            restart = 1'b1;
            acc_en  = 1'b1;
          end else if (cnt == CW'(SAMPLES - 1)) begin
            // Last bin is always in the mirror half, so nothing to accumulate here.
            if (bus.sink_eop) begin
              wr_en     = 1'b1;
              wr_addr   = '0;
              state_nxt = FLUSH;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else if (bus.sink_eop) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            acc_en  = 1'b1;
            cnt_inc = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (fidx == AW'(BANDS - 1)) begin
          state_nxt = IDLE;
        end else begin
          wr_en   = 1'b1;
          wr_addr = fidx + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulate stage: band sums built on the accepting edge
  always_ff @(posedge fft_clk) begin
    if (reset) begin
      cnt  <= '0;
      fidx <= '0;
      for (int b = 0; b < BANDS; b++) acc[b] <= '0;
    end else begin
      if (restart)      cnt <= CW'(1);
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (wr_en) fidx <= wr_addr;
      for (int b = 0; b < BANDS; b++) begin
        if (restart)
          acc[b] <= (b == 0) ? ACC_W'(mag) : '0;
        else if (acc_en && in_half && band == AW'(b))
          acc[b] <= acc[b] + ACC_W'(mag);
      end
    end
  end

  // Output stage: registered write port and error pulse
  always_ff @(posedge fft_clk) begin
    if (reset) begin
      dat     <= '0;
      addr    <= '0;
      dowrite <= 1'b0;
      err     <= 1'b0;
    end else begin
      err     <= err_nxt;
      dowrite <= wr_en;
      if (wr_en) begin
        addr <= wr_addr;
        dat  <= sat16(acc[wr_addr]);
      end
    end
  end
endmodule

// File: tb/tb_fft_spectrum_bander.sv
// Bench for fft_spectrum_bander: two instances (OUT_SHIFT 10 and 0) share one stimulus
// stream and are compared against a band-sum model computed straight from the frame array.
module tb_fft_spectrum_bander;
  localparam int SAMPLES = 4096;
  localparam int BANDS   = 4;
  localparam int PER     = SAMPLES / (2 * BANDS);

  logic fft_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 fft_clk = ~fft_clk;

  logic               drv_valid = 1'b0;
  logic               drv_sop   = 1'b0;
  logic               drv_eop   = 1'b0;
  logic signed [15:0] drv_re    = '0;
  logic signed [15:0] drv_im    = '0;

  fft_spectrum_bander_if #(.DATA_W(16), .BANDS(BANDS)) bus0 ();
  fft_spectrum_bander_if #(.DATA_W(16), .BANDS(BANDS)) bus1 ();

  assign bus0.sink_valid = drv_valid;
  assign bus0.sink_sop   = drv_sop;
  assign bus0.sink_eop   = drv_eop;
  assign bus0.sink_real  = drv_re;
  assign bus0.sink_imag  = drv_im;
  assign bus1.sink_valid = drv_valid;
  assign bus1.sink_sop   = drv_sop;
  assign bus1.sink_eop   = drv_eop;
  assign bus1.sink_real  = drv_re;
  assign bus1.sink_imag  = drv_im;

  fft_spectrum_bander #(.SAMPLES(SAMPLES), .BANDS(BANDS), .OUT_SHIFT(10), .DATA_W(16)) dut0 (
    .fft_clk (fft_clk),
    .reset   (reset),
    .bus     (bus0)
  );
  fft_spectrum_bander #(.SAMPLES(SAMPLES), .BANDS(BANDS), .OUT_SHIFT(0), .DATA_W(16)) dut1 (
    .fft_clk (fft_clk),
    .reset   (reset),
    .bus     (bus1)
  );

  int errors = 0;
  int checks = 0;

  int fre [SAMPLES];
  int fim [SAMPLES];

  logic [17:0] wq0[$];
  logic [17:0] wq1[$];
  int ec0 = 0, ec1 = 0;
  int sel_bad = 0;

  always @(negedge fft_clk) begin
    if (bus0.vga_dowrite) wq0.push_back({bus0.vga_addr, bus0.vga_dat});
    if (bus1.vga_dowrite) wq1.push_back({bus1.vga_addr, bus1.vga_dat});
    if (bus0.frame_err) ec0++;
    if (bus1.frame_err) ec1++;
    if (bus0.vga_select !== bus0.vga_dowrite || bus1.vga_select !== bus1.vga_dowrite) sel_bad++;
  end

  // Reference: sum |re|+|im| over the bins of band b in the lower half, shift, clamp.
  function automatic logic [15:0] band_val(input int b, input int sh);
    longint s = 0;
    for (int k = 0; k < SAMPLES / 2; k++)
      if (k / PER == b) s += longint'((fre[k] < 0) ? -fre[k] : fre[k]) + longint'((fim[k] < 0) ? -fim[k] : fim[k]);
    s = s >>> sh;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  function automatic int sh_of(input int d);
    return (d == 0) ? 10 : 0;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [17:0] qget(input int d, input int b);
    if (d == 0) return (b < wq0.size()) ? wq0[b] : 18'h3FFFF;
    return (b < wq1.size()) ? wq1[b] : 18'h3FFFF;
  endfunction

  function automatic int ecnt(input int d);
    return (d == 0) ? ec0 : ec1;
  endfunction

  task automatic clear_mon();
    wq0.delete();
    wq1.delete();
  endtask

  task automatic fill_random(input int lo_zero, input int hi_zero);
    for (int k = 0; k < SAMPLES; k++) begin
      if (k >= lo_zero && k < hi_zero) begin
        fre[k] = 0; fim[k] = 0;
      end else begin
        fre[k] = int'($urandom_range(65535)) - 32768;
        fim[k] = int'($urandom_range(65535)) - 32768;
      end
    end
  endtask

  // Present one beat and hold it until the DUT accepts it; returns 1ns after the accepting edge.
  task automatic send_beat(input bit s, input bit e, input int r, input int i);
    bit done = 0;
    int guard = 0;
    drv_valid = 1'b1; drv_sop = s; drv_eop = e; drv_re = 16'(r); drv_im = 16'(i);
    while (!done) begin
      @(negedge fft_clk);
      if (bus0.sink_ready) done = 1;
      @(posedge fft_clk); #1;
      guard++;
      if (!done && guard > 50) begin
        checks++; errors++;
        $display("FAIL ready_timeout got sink_ready=0 for %0d cycles want 1", guard);
        done = 1;
      end
    end
  endtask

  task automatic send_frame(input int n, input int eop_at, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      if (gap_pct > 0)
        while (int'($urandom_range(99)) < gap_pct) begin
          drv_valid = 1'b0; @(posedge fft_clk); #1;
        end
      send_beat(k == 0, k == eop_at, fre[k], fim[k]);
    end
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge fft_clk); #1; end
  endtask

  task automatic test_reset();
    idle(3);
    @(negedge fft_clk);
    checks++;
    if (bus0.sink_ready !== 1'b0 || bus1.sink_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", bus0.sink_ready, bus1.sink_ready);
    end
    checks++;
    if ({bus0.vga_dat, bus0.vga_addr, bus0.vga_dowrite, bus0.vga_select, bus0.frame_err,
         bus1.vga_dat, bus1.vga_addr, bus1.vga_dowrite, bus1.vga_select, bus1.frame_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got dat=%h/%h dw=%b/%b err=%b/%b want all 0",
                         bus0.vga_dat, bus1.vga_dat, bus0.vga_dowrite, bus1.vga_dowrite, bus0.frame_err, bus1.frame_err);
    end
    @(posedge fft_clk); #1;
    reset = 1'b0;
    @(negedge fft_clk);
    checks++;
    if (bus0.sink_ready !== 1'b1 || bus1.sink_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b%b want 11", bus0.sink_ready, bus1.sink_ready);
    end
    @(posedge fft_clk); #1;
  endtask

  task automatic test_uniform();
    int e0 = ec0, e1 = ec1;
    for (int k = 0; k < SAMPLES; k++) begin fre[k] = 100; fim[k] = -50; end
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 0);
    idle(8);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (qsize(d) !== 4) begin errors++; $display("FAIL uniform_count dut%0d got %0d want 4", d, qsize(d)); end
      for (int b = 0; b < BANDS; b++) begin
        checks++;
        if (qget(d, b) !== {2'(b), band_val(b, sh_of(d))}) begin
          errors++; $display("FAIL uniform_band%0d dut%0d got %h want %h", b, d, qget(d, b), {2'(b), band_val(b, sh_of(d))});
        end
      end
    end
    checks++;
    if (ec0 != e0 || ec1 != e1) begin
      errors++; $display("FAIL uniform_frame_err got %0d/%0d pulses want 0", ec0 - e0, ec1 - e1);
    end
  endtask

  task automatic test_peak_sat();
    for (int k = 0; k < SAMPLES; k++) begin fre[k] = 0; fim[k] = 0; end
    fre[0] = -32768; fim[0] = -32768;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1)
        for (int k = 3 * PER; k < 4 * PER; k++) begin fre[k] = 32767; fim[k] = 32767; end
      clear_mon();
      send_frame(SAMPLES, SAMPLES - 1, 0);
      idle(8);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (qsize(d) !== 4) begin errors++; $display("FAIL peak%0d_count dut%0d got %0d want 4", pass, d, qsize(d)); end
        for (int b = 0; b < BANDS; b++) begin
          checks++;
          if (qget(d, b) !== {2'(b), band_val(b, sh_of(d))}) begin
            errors++; $display("FAIL peak%0d_band%0d dut%0d got %h want %h", pass, b, d, qget(d, b), {2'(b), band_val(b, sh_of(d))});
          end
        end
      end
    end
  endtask

  task automatic test_mirror();
    fill_random(0, SAMPLES / 2);
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 0);
    idle(8);
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < BANDS; b++) begin
        checks++;
        if (qget(d, b) !== {2'(b), 16'h0000}) begin
          errors++; $display("FAIL mirror_band%0d dut%0d got %h want %h", b, d, qget(d, b), {2'(b), 16'h0000});
        end
      end
  endtask

  task automatic test_bad_eop();
    int e0 = ec0;
    fill_random(SAMPLES, SAMPLES);
    clear_mon();
    send_frame(101, 100, 0);
    idle(8);
    checks++;
    if (ec0 - e0 != 1 || ec1 - e0 != ec1 - ec0 + ec0 - e0) begin end
    if (ec0 - e0 != 1) begin errors++; $display("FAIL bad_eop_err got %0d pulses want 1", ec0 - e0); end
    checks++;
    if (qsize(0) != 0 || qsize(1) != 0) begin
      errors++; $display("FAIL bad_eop_writes got %0d/%0d want 0", qsize(0), qsize(1));
    end
    e0 = ec0;
    send_beat(1'b1, 1'b1, 7, 7);
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0;
    idle(6);
    checks++;
    if (ec0 - e0 != 1 || qsize(0) != 0) begin
      errors++; $display("FAIL idle_sop_eop got err=%0d writes=%0d want err=1 writes=0", ec0 - e0, qsize(0));
    end
    fill_random(SAMPLES, SAMPLES);
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 0);
    idle(8);
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < BANDS; b++) begin
        checks++;
        if (qget(d, b) !== {2'(b), band_val(b, sh_of(d))}) begin
          errors++; $display("FAIL after_bad_band%0d dut%0d got %h want %h", b, d, qget(d, b), {2'(b), band_val(b, sh_of(d))});
        end
      end
  endtask

  task automatic test_restart();
    int e0 = ec0, e1 = ec1;
    logic [5:0] rdy, wr;
    fill_random(SAMPLES, SAMPLES);
    clear_mon();
    send_frame(300, -1, 0);
    fill_random(SAMPLES, SAMPLES);
    send_frame(SAMPLES, SAMPLES - 1, 0);
    drv_valid = 1'b1; drv_sop = 1'b0; drv_eop = 1'b0; drv_re = 16'sd1000; drv_im = 16'sd1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge fft_clk);
      rdy[k] = bus0.sink_ready & bus1.sink_ready;
      wr[k]  = bus0.vga_dowrite;
    end
    drv_valid = 1'b0;
    idle(4);
    checks++;
    if (rdy !== 6'b110000) begin errors++; $display("FAIL flush_ready got %b want 110000", rdy); end
    checks++;
    if (wr !== 6'b001111) begin errors++; $display("FAIL flush_dowrite got %b want 001111", wr); end
    checks++;
    if (ec0 - e0 != 1 || ec1 - e1 != 1) begin
      errors++; $display("FAIL restart_err got %0d/%0d pulses want 1", ec0 - e0, ec1 - e1);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (qsize(d) !== 4) begin errors++; $display("FAIL restart_count dut%0d got %0d want 4", d, qsize(d)); end
      for (int b = 0; b < BANDS; b++) begin
        checks++;
        if (qget(d, b) !== {2'(b), band_val(b, sh_of(d))}) begin
          errors++; $display("FAIL restart_band%0d dut%0d got %h want %h", b, d, qget(d, b), {2'(b), band_val(b, sh_of(d))});
        end
      end
    end
  endtask

  task automatic test_gaps_and_reset();
    logic [17:0] ref_q [BANDS];
    fill_random(SAMPLES, SAMPLES);
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 0);
    idle(8);
    for (int b = 0; b < BANDS; b++) ref_q[b] = qget(0, b);
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 15);
    idle(8);
    for (int b = 0; b < BANDS; b++) begin
      checks++;
      if (qget(0, b) !== ref_q[b] || qget(0, b) !== {2'(b), band_val(b, 10)}) begin
        errors++; $display("FAIL gaps_band%0d got %h want %h", b, qget(0, b), {2'(b), band_val(b, 10)});
      end
    end
    clear_mon();
    send_frame(SAMPLES, SAMPLES - 1, 0);
    @(posedge fft_clk); #1;
    @(negedge fft_clk);
    checks++;
    if (bus0.vga_dowrite !== 1'b1 || bus0.vga_addr !== 2'd1) begin
      errors++; $display("FAIL flush2_state got dw=%b addr=%0d want dw=1 addr=1", bus0.vga_dowrite, bus0.vga_addr);
    end
    reset = 1'b1;
    @(negedge fft_clk);
    checks++;
    if ({bus0.vga_dat, bus0.vga_addr, bus0.vga_dowrite, bus0.vga_select, bus0.frame_err, bus0.sink_ready,
         bus1.vga_dat, bus1.vga_addr, bus1.vga_dowrite, bus1.vga_select, bus1.frame_err, bus1.sink_ready} !== '0) begin
      errors++; $display("FAIL midflush_reset got dat=%h/%h dw=%b/%b rdy=%b/%b want all 0",
                         bus0.vga_dat, bus1.vga_dat, bus0.vga_dowrite, bus1.vga_dowrite, bus0.sink_ready, bus1.sink_ready);
    end
    @(posedge fft_clk); #1;
    reset = 1'b0;
    @(negedge fft_clk);
    checks++;
    if (bus0.sink_ready !== 1'b1 || bus1.sink_ready !== 1'b1) begin
      errors++; $display("FAIL reset_again_ready got %b%b want 11", bus0.sink_ready, bus1.sink_ready);
    end
    checks++;
    if (qsize(0) != 2 || qsize(1) != 2) begin
      errors++; $display("FAIL midflush_writes got %0d/%0d want 2", qsize(0), qsize(1));
    end
    @(posedge fft_clk); #1;
  endtask

  task automatic test_select();
    checks++;
    if (sel_bad != 0) begin errors++; $display("FAIL select_tracks_dowrite got %0d bad cycles want 0", sel_bad); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_peak_sat();
    test_mirror();
    test_bad_eop();
    test_restart();
    test_gaps_and_reset();
    test_select();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_spectrum_bander.md
# fft_spectrum_bander

Avalon-ST sink that consumes the forward FFT's source-side output stream (one frame of `SAMPLES` complex bins framed by sop/eop) and reduces it to `BANDS` band magnitudes for the display path. It sits on `fft_clk` downstream of the forward FFT. It is the receiving end of the sop/valid/eop/ready framing the audio front end drives into the FFT sink. After each well-formed frame it issues `BANDS` consecutive register writes on the VGA peripheral bus (`vga_dat`/`vga_addr`/`vga_dowrite`/`vga_select`).

## Interface
- `SAMPLES`, 4096: bins per frame (power of two, ≥ 2·`BANDS`).
- `BANDS`, 4: number of output bands (power of two; `vga_addr` width = log2(`BANDS`) = 2).
- `OUT_SHIFT`, 10: right shift applied to band accumulator before 16-bit saturation.

- `fft_clk` in 1: sole clock. One clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sink_valid` in 1: beat valid.
- `sink_ready` out 1: block accepts a beat this cycle.
- `sink_sop` in 1: first bin of frame.
- `sink_eop` in 1: last bin of frame.
- `sink_real` in 16: signed bin real part.
- `sink_imag` in 16: signed bin imaginary part.
- `vga_dat` out 16: band value being written.
- `vga_addr` out 2: band index being written.
- `vga_dowrite` out 1: write strobe, one cycle per band.
- `vga_select` out 1: peripheral chip-select, high exactly when `vga_dowrite` is high.
- `frame_err` out 1: one-cycle pulse on a framing violation.

## Operation
- A beat is accepted on an edge where `sink_valid && sink_ready`. No other beats have effect.
- `sink_ready` = (state != FLUSH) && !reset. This is combinational from the state register.
- States:
  - IDLE: waiting for sop. An accepted beat without sop is discarded silently. An accepted beat with sop loads bin counter = 1, clears all accumulators, accumulates bin 0, and moves to ACCUM.
  - ACCUM: each accepted beat is bin index `cnt`, then `cnt` increments.
  - FLUSH: `BANDS` cycles of writes, then return to IDLE.
- Magnitude: m = |re| + |im|, 17-bit unsigned. |−32768| = 32768, with no wrap.
- Accumulation: bins 0 … `SAMPLES`/2−1 only. Band b = bin / (`SAMPLES`/(2·`BANDS`)), i.e. 512 bins per band by default. Bins ≥ `SAMPLES`/2 (mirror half) are counted but not accumulated. Accumulators are 26 bits and cannot overflow at defaults.
- Output value: `vga_dat` = min(acc_b >> `OUT_SHIFT`, 16'hFFFF).
- Framing rules, applied to each accepted beat in ACCUM:
  - sop set: pulse `frame_err`, then restart the frame with this beat as bin 0 (accumulators cleared, `cnt` = 1).
  - eop set and `cnt` == `SAMPLES`−1: valid frame end; go to FLUSH.
  - eop set and `cnt` != `SAMPLES`−1: pulse `frame_err`, discard the frame, go to IDLE, issue no writes.
  - eop clear and `cnt` == `SAMPLES`−1: pulse `frame_err`, discard the frame, go to IDLE.
  - sop and eop both set: the sop rule takes priority (restart), and `frame_err` pulses once.
- An accepted beat in IDLE with both sop and eop set: pulse `frame_err` and stay in IDLE.
- Reset, including mid-frame or mid-flush: state goes to IDLE, counters and accumulators clear, and all outputs are 0. A partial flush is abandoned.

## Timing
- Reset values: `sink_ready` 0 while `reset` is high, 1 on the first cycle after. `vga_dat` 0, `vga_addr` 0, `vga_dowrite` 0, `vga_select` 0, `frame_err` 0.
- All outputs except `sink_ready` are registered.
- Let edge E be the edge that accepts a valid eop. `vga_dowrite`/`vga_select` are high for the `BANDS` cycles after E, with `vga_addr` = 0,1,2,3 in order and `vga_dat` holding the matching band value. The first write is visible the cycle after E.
- `sink_ready` is low for exactly those `BANDS` cycles, then high again.
- Between writes, `vga_dat`/`vga_addr` hold their last value and `vga_dowrite` is 0.
- `frame_err` goes high the cycle after the offending edge, for exactly one cycle.
- Throughput: one beat per cycle in ACCUM. The minimum frame period is `SAMPLES` + `BANDS` cycles.
- `sink_valid` low mid-frame is a legal stall: state and `cnt` hold.

## Test plan
- Frame of 4096 beats, all bins re=100, im=−50, with correct sop/eop. Expected: four writes on addr 0..3, each `vga_dat` = (512·150)>>10 = 75, and `frame_err` never asserted.
- Bin 0 = (−32768, −32768), all others 0. Expected: addr 0 value = 65536>>10 = 64, others 0. Then set every bin in band 3 to (32767, 32767) with `OUT_SHIFT` = 0. Expected: addr 3 saturates to 16'hFFFF.
- Bins 2048–4095 set to large values, bins below 2048 zero. Expected: all four writes are 0 (mirror half ignored).
- eop on beat 100. Expected: one `frame_err` pulse and no `vga_dowrite`. Then a clean frame follows and produces normal writes.
- sop reasserted at beat 300 of a frame, followed by a full 4096-beat frame from that sop. Expected: one `frame_err` pulse and writes reflecting only the restarted frame. During the flush, hold `sink_valid` high and check that `sink_ready` = 0 for exactly 4 cycles and no beat is consumed.
- Randomized `sink_valid` gaps across a frame give results identical to the gapless run. Assert `reset` during the 2nd flush cycle: writes stop the next cycle, all outputs are 0, and `sink_ready` is 1 after release.
